popcnt_seq: RTL and testbench
=============================

POPCNT_SEQ -- requirements
Module: popcnt_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning input vector width in bits (1..1024).
REQ-002 SHALL have parameter LANES, default 1, meaning number of 6-bit slices counted per cycle (1..8).
REQ-003 SHALL have parameter ABSTRACT_MODEL, default 0: 1 selects a behavioural single-expression count with identical cycle timing.
REQ-004 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 i_rst  input  1  reset, asynchronous and active-high.
REQ-006 i_x  input  WIDTH  vector to count; sampled only on the input handshake.
REQ-007 i_valid  input  1  i_x is valid.
REQ-008 o_ready  output  1  block can accept i_x.
REQ-009 o_count  output  CW  population count, where CW = $clog2(WIDTH+1).
REQ-010 o_valid  output  1  o_count is valid.
REQ-011 i_ready  input  1  downstream accepts o_count.

Function
REQ-012 SHALL define CHUNK = 6*LANES and NCHUNK = ceil(WIDTH/CHUNK), and zero-pad i_x to NCHUNK*CHUNK bits.
REQ-013 SHALL implement states IDLE, BUSY and DONE.
REQ-014 IDLE: o_ready=1 and o_valid=0; on i_valid&&o_ready, SHALL capture padded i_x, clear the accumulator and the chunk index, and go to BUSY.
REQ-015 BUSY: o_ready=0 and o_valid=0; each cycle SHALL add the popcounts of chunk[index] to the accumulator and increment the index; after chunk NCHUNK-1 it SHALL go to DONE.
REQ-016 DONE: o_valid=1 and o_count=accumulator, held stable while i_ready=0; on i_ready it SHALL go to IDLE.
REQ-017 Latency SHALL be NCHUNK+1 cycles from the input handshake edge to o_valid=1.
REQ-018 Peak throughput SHALL be one vector per NCHUNK+2 cycles; input acceptance and output handshake never coincide.
REQ-019 The accumulator SHALL be CW bits wide and SHALL never overflow; maximum value is WIDTH.
REQ-020 Padding bits SHALL never contribute to the count.
REQ-021 i_x changes outside the input handshake SHALL have no effect.
REQ-022 i_valid during BUSY or DONE SHALL be ignored; the input is not consumed.

Reset
REQ-023 Asserting i_rst at any time, including mid-BUSY, SHALL immediately force IDLE, o_ready=1, o_valid=0, o_count=0, accumulator=0 and index=0.
REQ-024 After i_rst deasserts, the first rising edge SHALL behave as IDLE; a partial count is never emitted.

Configuration
REQ-025 Macro POPCNT_SEQ_THRESHOLD_EN, when defined, SHALL add input i_threshold (CW bits), sampled with i_x, and output o_geThreshold (1 bit).
REQ-026 With the macro defined, o_geThreshold SHALL equal (o_count >= captured threshold) whenever o_valid=1, and 0 otherwise, including after reset.
REQ-027 Without the macro, neither port nor its logic SHALL exist; all other behaviour is identical.

Structure
REQ-028 Package popcnt_pkg SHALL hold the state enum type (IDLE/BUSY/DONE) and a function computing CW from a width.
REQ-029 The per-cycle count SHALL use LANES instances of existing sub-module popcnt6, each with ABSTRACT_MODEL passed through, summed by a combinational adder tree.
REQ-030 ABSTRACT_MODEL=1 SHALL replace the popcnt6 lanes with a behavioural count of the chunk.

Verification
REQ-031 WIDTH=32, LANES=1, i_x=32'hFFFFFFFF, i_ready=1 -> o_valid rises 7 cycles after the handshake with o_count=32, and o_ready returns 1 one cycle later.
REQ-032 WIDTH=32, LANES=2, i_x=32'h0000_0001 -> o_count=1 after 4 cycles; padding is ignored.
REQ-033 i_ready held 0 for 5 cycles in DONE -> o_valid and o_count stay stable, and i_valid pulses are ignored.
REQ-034 i_rst pulsed during the 3rd BUSY cycle -> asynchronous return to IDLE, o_count=0, and no o_valid pulse.
REQ-035 Randomised i_x, 1000 vectors, with ABSTRACT_MODEL=0 and =1 instances in parallel -> counts match each other and $countones(i_x), with identical timing.
REQ-036 With POPCNT_SEQ_THRESHOLD_EN defined, i_x=32'h0F, i_threshold=4 -> o_geThreshold=1; with i_threshold=5 -> o_geThreshold=0.

Source files
------------

// File: rtl/popcnt_seq_pkg.sv
// Shared types and helpers for the sequential population counter.
package popcnt_pkg;

    // Controller states: accept a vector, count it chunk by chunk, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold any count from 0 to width inclusive.
    function automatic int calc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/popcnt_seq_if.sv
// Bundle of the input and output handshakes of the population counter.
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; the sender holds its payload stable until that edge, and the
// receiver may drive ready independently of valid.
// Optional threshold compare is present when POPCNT_SEQ_THRESHOLD_EN is defined.
interface popcnt_seq_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
);
    logic [WIDTH-1:0] x;
    logic             valid;
    logic             ready;
    logic [CW-1:0]    count;
    logic             count_valid;
    logic             count_ready;
`ifdef POPCNT_SEQ_THRESHOLD_EN
    logic [CW-1:0]    threshold;
    logic             ge_threshold;

    modport master (
        output x, valid, count_ready, threshold,
        input  ready, count, count_valid, ge_threshold
    );
    modport slave (
        input  x, valid, count_ready, threshold,
        output ready, count, count_valid, ge_threshold
    );
`else
    modport master (
        output x, valid, count_ready,
        input  ready, count, count_valid
    );
    modport slave (
        input  x, valid, count_ready,
        output ready, count, count_valid
    );
`endif
endinterface

// File: rtl/popcnt6.sv
// Population count of a 6-bit slice. ABSTRACT_MODEL=1 uses a behavioural count,
// otherwise two full adders whose 2-bit results are summed.
module popcnt6 #(
    parameter int ABSTRACT_MODEL = 0
) (
    input  logic [5:0] i_x,
    output logic [2:0] o_count
);
    generate
        if (ABSTRACT_MODEL != 0) begin : g_abs
            assign o_count = 3'($countones(i_x));
        end else begin : g_gate
            logic w_s0, w_c0, w_s1, w_c1;
            assign w_s0 = i_x[0] ^ i_x[1] ^ i_x[2];
            assign w_c0 = (i_x[0] & i_x[1]) | (i_x[0] & i_x[2]) | (i_x[1] & i_x[2]);
            assign w_s1 = i_x[3] ^ i_x[4] ^ i_x[5];
            assign w_c1 = (i_x[3] & i_x[4]) | (i_x[3] & i_x[5]) | (i_x[4] & i_x[5]);
            // Each full adder yields 0..3; their sum is at most 6 and fits 3 bits.
            assign o_count = {1'b0, w_c0, w_s0} + {1'b0, w_c1, w_s1};
        end
    endgenerate
endmodule

// File: rtl/popcnt_seq_core.sv
// Controller and datapath of the sequential population counter. The vector is
// zero-padded to a whole number of chunks and shifted down one chunk per BUSY
// cycle, so padding bits only ever add zero.
// Optional threshold compare is present when POPCNT_SEQ_THRESHOLD_EN is defined.
module popcnt_seq_core
    import popcnt_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int LANES          = 1,
    parameter int ABSTRACT_MODEL = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    popcnt_seq_if.slave bus
);
    localparam int CW     = calc_cw(WIDTH);
    localparam int CHUNK  = 6 * LANES;
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CCW    = $clog2(CHUNK + 1);
    localparam int SW     = (CW > CCW) ? CW : CCW;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_ready;
    logic             w_valid;
    logic             w_accept;
    logic [PW-1:0]    r_data;
    logic [CW-1:0]    r_acc;
    logic [IW-1:0]    r_idx;
    logic [CHUNK-1:0] w_chunk;
    logic [CCW-1:0]   w_chunk_cnt;
    logic [SW-1:0]    w_sum;

    assign w_chunk  = r_data[CHUNK-1:0];
    assign w_accept = w_ready && bus.valid;
    // The true total never exceeds WIDTH, so truncating back to CW bits is lossless.
    assign w_sum    = SW'(r_acc) + SW'(w_chunk_cnt);

    generate
        if (ABSTRACT_MODEL != 0) begin : g_abs
            assign w_chunk_cnt = CCW'($countones(w_chunk));
        end else begin : g_lanes
            logic [2:0]     w_lane_cnt [8];
            logic [CCW-1:0] w_t1 [4];
            logic [CCW-1:0] w_t2 [2];
            for (genvar l = 0; l < 8; l++) begin : g_lane
                if (l < LANES) begin : g_used
                    popcnt6 #(.ABSTRACT_MODEL(ABSTRACT_MODEL)) u_pc (
                        .i_x     (w_chunk[6*l +: 6]),
                        .o_count (w_lane_cnt[l])
                    );
                end else begin : g_unused
                    assign w_lane_cnt[l] = 3'd0;
                end
            end
            // Balanced three-level adder tree over eight (possibly empty) lanes.
            always_comb begin
                for (int i = 0; i < 4; i++) begin
                    w_t1[i] = CCW'(w_lane_cnt[2*i]) + CCW'(w_lane_cnt[2*i+1]);
                end
                for (int i = 0; i < 2; i++) begin
                    w_t2[i] = w_t1[2*i] + w_t1[2*i+1];
                end
            end
            assign w_chunk_cnt = w_t2[0] + w_t2[1];
        end
    endgenerate

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.valid) w_next = BUSY;
            end
            BUSY: begin
                if (r_idx == LAST) w_next = DONE;
            end
            DONE: begin
                w_valid = 1'b1;
                if (bus.count_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture on acceptance, then consume one chunk per BUSY cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_acc  <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_data <= PW'(bus.x);
            r_acc  <= '0;
            r_idx  <= '0;
        end else if (r_state == BUSY) begin
            r_data <= r_data >> CHUNK;
            r_acc  <= CW'(w_sum);
            r_idx  <= r_idx + 1'b1;
        end
    end

    assign bus.ready       = w_ready;
    assign bus.count_valid = w_valid;
    // Count is only visible in DONE, so a partial sum never leaks out.
    assign bus.count       = w_valid ? r_acc : '0;

`ifdef POPCNT_SEQ_THRESHOLD_EN
    logic [CW-1:0] r_thr;

    // Threshold is sampled together with the vector.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_thr <= '0;
        end else if (w_accept) begin
            r_thr <= bus.threshold;
        end
    end

    assign bus.ge_threshold = w_valid && (r_acc >= r_thr);
`endif
endmodule

// File: rtl/popcnt_seq.sv
// Top of the sequential population counter: counts 6*LANES bits per cycle.
// Optional threshold compare is present when POPCNT_SEQ_THRESHOLD_EN is defined.
module popcnt_seq
    import popcnt_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int LANES          = 1,
    parameter int ABSTRACT_MODEL = 0,
    localparam int CW            = calc_cw(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [CW-1:0]    o_count,
    output logic             o_valid,
`ifdef POPCNT_SEQ_THRESHOLD_EN
    input  logic             i_ready,
    input  logic [CW-1:0]    i_threshold,
    output logic             o_geThreshold
`else
    input  logic             i_ready
`endif
);
    popcnt_seq_if #(.WIDTH(WIDTH), .CW(CW)) w_bus ();

    assign w_bus.x           = i_x;
    assign w_bus.valid       = i_valid;
    assign w_bus.count_ready = i_ready;
    assign o_ready           = w_bus.ready;
    assign o_count           = w_bus.count;
    assign o_valid           = w_bus.count_valid;
`ifdef POPCNT_SEQ_THRESHOLD_EN
    assign w_bus.threshold   = i_threshold;
    assign o_geThreshold     = w_bus.ge_threshold;
`endif

    popcnt_seq_core #(
        .WIDTH          (WIDTH),
        .LANES          (LANES),
        .ABSTRACT_MODEL (ABSTRACT_MODEL)
    ) u_core (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (w_bus.slave)
    );
endmodule

// File: tb/tb_popcnt_seq.sv
// Bench for popcnt_seq: table of directed vectors plus hand-written corner sequences.
// Inputs are driven and outputs sampled on the falling edge.
module tb_popcnt_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    popcnt_seq_if #(.WIDTH(32), .CW(6)) bus_a ();
    popcnt_seq_if #(.WIDTH(32), .CW(6)) bus_c ();

    logic       b_ready;
    logic [5:0] b_count;
    logic       b_valid;
`ifdef POPCNT_SEQ_THRESHOLD_EN
    logic       b_ge;
`endif

    // A: gate-level lanes, LANES=1.
    popcnt_seq #(.WIDTH(32), .LANES(1), .ABSTRACT_MODEL(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_x(bus_a.x), .i_valid(bus_a.valid),
        .o_ready(bus_a.ready), .o_count(bus_a.count), .o_valid(bus_a.count_valid),
`ifdef POPCNT_SEQ_THRESHOLD_EN
        .i_ready(bus_a.count_ready), .i_threshold(bus_a.threshold),
        .o_geThreshold(bus_a.ge_threshold)
`else
        .i_ready(bus_a.count_ready)
`endif
    );

    // B: behavioural model, same inputs as A.
    popcnt_seq #(.WIDTH(32), .LANES(1), .ABSTRACT_MODEL(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_x(bus_a.x), .i_valid(bus_a.valid),
        .o_ready(b_ready), .o_count(b_count), .o_valid(b_valid),
`ifdef POPCNT_SEQ_THRESHOLD_EN
        .i_ready(bus_a.count_ready), .i_threshold(bus_a.threshold),
        .o_geThreshold(b_ge)
`else
        .i_ready(bus_a.count_ready)
`endif
    );

    // C: two lanes, 12-bit chunks, 4 padding bits in the last chunk.
    popcnt_seq #(.WIDTH(32), .LANES(2), .ABSTRACT_MODEL(0)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_x(bus_c.x), .i_valid(bus_c.valid),
        .o_ready(bus_c.ready), .o_count(bus_c.count), .o_valid(bus_c.count_valid),
`ifdef POPCNT_SEQ_THRESHOLD_EN
        .i_ready(bus_c.count_ready), .i_threshold(bus_c.threshold),
        .o_geThreshold(bus_c.ge_threshold)
`else
        .i_ready(bus_c.count_ready)
`endif
    );

    typedef struct {
        logic [31:0] x;
        int          cnt;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_skew   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic cur_valid(input int sel);
        return (sel == 0) ? bus_a.count_valid : bus_c.count_valid;
    endfunction

    // Handshake one vector; caller is at a falling edge with the DUT idle.
    task automatic send(input int sel, input logic [31:0] x);
        if (sel == 0) begin
            bus_a.x = x; bus_a.valid = 1'b1;
        end else begin
            bus_c.x = x; bus_c.valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble the bus after the handshake: it must not matter.
        if (sel == 0) begin
            bus_a.valid = 1'b0; bus_a.x = $urandom();
`ifdef POPCNT_SEQ_THRESHOLD_EN
            bus_a.threshold = 6'($urandom_range(0, 63));
`endif
        end else begin
            bus_c.valid = 1'b0; bus_c.x = $urandom();
        end
    endtask

    // Returns rising edges from the handshake edge (counted as 1) to o_valid.
    task automatic wait_done(input int sel, output int edges);
        edges = 1;
        while (!cur_valid(sel) && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (sel == 0 && b_valid !== bus_a.count_valid) n_skew++;
        end
        if (!cur_valid(sel)) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_done timeout: got o_valid=0 expected 1 within 40 cycles");
        end
    endtask

    task automatic run_vec(input int sel, input logic [31:0] x, input int exp_cnt,
                           input int exp_lat, input string tag);
        int lat;
        send(sel, x);
        wait_done(sel, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (sel == 0) begin
            check({tag, " count"}, 32'(bus_a.count), 32'(exp_cnt));
            check({tag, " abstract count"}, 32'(b_count), 32'(exp_cnt));
            check({tag, " abstract valid"}, 32'(b_valid), 32'd1);
        end else begin
            check({tag, " count"}, 32'(bus_c.count), 32'(exp_cnt));
        end
        @(posedge clk);
        @(negedge clk);
        if (sel == 0) begin
            check({tag, " ready after"}, 32'(bus_a.ready), 32'd1);
            check({tag, " valid after"}, 32'(bus_a.count_valid), 32'd0);
            check({tag, " abstract ready after"}, 32'(b_ready), 32'd1);
        end else begin
            check({tag, " ready after"}, 32'(bus_c.ready), 32'd1);
            check({tag, " valid after"}, 32'(bus_c.count_valid), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int spur;
        logic [31:0] rx;

        vecs[0] = '{32'h0000_0000, 0};
        vecs[1] = '{32'hFFFF_FFFF, 32};
        vecs[2] = '{32'h0000_0001, 1};
        vecs[3] = '{32'h8000_0000, 1};
        vecs[4] = '{32'hAAAA_AAAA, 16};
        vecs[5] = '{32'h0000_003F, 6};
        vecs[6] = '{32'hF0F0_00FF, 16};
        vecs[7] = '{32'hDEAD_BEEF, 24};

        bus_a.x = '0; bus_a.valid = 1'b0; bus_a.count_ready = 1'b1;
        bus_c.x = '0; bus_c.valid = 1'b0; bus_c.count_ready = 1'b1;
`ifdef POPCNT_SEQ_THRESHOLD_EN
        bus_a.threshold = '0; bus_c.threshold = '0;
`endif
        repeat (3) @(negedge clk);
        check("reset ready a", 32'(bus_a.ready), 32'd1);
        check("reset valid a", 32'(bus_a.count_valid), 32'd0);
        check("reset count a", 32'(bus_a.count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle ready c", 32'(bus_c.ready), 32'd1);
        check("idle valid c", 32'(bus_c.count_valid), 32'd0);
`ifdef POPCNT_SEQ_THRESHOLD_EN
        check("reset ge a", 32'(bus_a.ge_threshold), 32'd0);
`endif

        // Table: LANES=1 takes 7 edges (6 chunks + handshake), LANES=2 takes 4.
        for (int i = 0; i < 8; i++) begin
            run_vec(0, vecs[i].x, vecs[i].cnt, 7, $sformatf("vec%0d a", i));
            run_vec(1, vecs[i].x, vecs[i].cnt, 4, $sformatf("vec%0d c", i));
        end

        // Output back-pressure: result held, input pulses ignored.
        bus_a.count_ready = 1'b0;
        begin
            int lat;
            send(0, 32'hAAAA_AAAA);
            wait_done(0, lat);
        end
        for (int i = 0; i < 5; i++) begin
            bus_a.valid = 1'b1;
            bus_a.x = $urandom();
            @(posedge clk);
            @(negedge clk);
            check($sformatf("stall%0d valid", i), 32'(bus_a.count_valid), 32'd1);
            check($sformatf("stall%0d count", i), 32'(bus_a.count), 32'd16);
            check($sformatf("stall%0d ready", i), 32'(bus_a.ready), 32'd0);
        end
        bus_a.valid = 1'b0;
        bus_a.count_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall release valid", 32'(bus_a.count_valid), 32'd0);
        check("stall release ready", 32'(bus_a.ready), 32'd1);
        spur = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_a.count_valid !== 1'b0) spur++;
        end
        check("stall pulses not consumed", 32'(spur), 32'd0);

        // Asynchronous reset in the third BUSY cycle.
        send(0, 32'hFFFF_FFFF);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst ready", 32'(bus_a.ready), 32'd1);
        check("async rst valid", 32'(bus_a.count_valid), 32'd0);
        check("async rst count", 32'(bus_a.count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        spur = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus_a.count_valid !== 1'b0 || bus_a.ready !== 1'b1) spur++;
        end
        check("no partial result after rst", 32'(spur), 32'd0);
        run_vec(0, 32'h0000_00FF, 8, 7, "post rst");

`ifdef POPCNT_SEQ_THRESHOLD_EN
        begin
            int lat;
            bus_a.threshold = 6'd4;
            send(0, 32'h0000_000F);
            wait_done(0, lat);
            check("thr4 ge a", 32'(bus_a.ge_threshold), 32'd1);
            check("thr4 ge b", 32'(b_ge), 32'd1);
            @(posedge clk);
            @(negedge clk);
            check("thr idle ge", 32'(bus_a.ge_threshold), 32'd0);
            bus_a.threshold = 6'd5;
            send(0, 32'h0000_000F);
            wait_done(0, lat);
            check("thr5 ge a", 32'(bus_a.ge_threshold), 32'd0);
            @(posedge clk);
            @(negedge clk);
            bus_a.threshold = 6'd32;
            send(0, 32'hFFFF_FFFF);
            wait_done(0, lat);
            check("thr32 ge a", 32'(bus_a.ge_threshold), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
`endif

        // Random vectors on the gate-level and behavioural instances in parallel.
        for (int i = 0; i < 1000; i++) begin
            rx = $urandom();
            run_vec(0, rx, $countones(rx), 7, $sformatf("rand%0d", i));
        end
        check("abstract timing skew", 32'(n_skew), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
